// File: rtl/piano_source_arbiter_pkg.sv
// Shared types and constants for the piano note-source arbiter.
// Note IDs, source codes, FSM states and a small sizing helper.
package piano_pkg;

    localparam int KEY_ID_BITS = 4;
    localparam logic [KEY_ID_BITS-1:0] REST = '0;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_LIVE = 2'b01;
    localparam logic [1:0] SRC_SONG = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SONG,
        S_LIVE_OVR,
        S_HOLDOFF,
        S_GAP
    } arb_state_t;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piano_source_arbiter_if.sv
// Note-source bundle between the live keyboard, song player,
// arbiter and tone generator.
interface piano_source_if;
    import piano_pkg::*;

    logic                   play_toggle_pulse;
    logic [KEY_ID_BITS-1:0] live_key_id;
    logic                   live_key_pressed;
    logic                   live_octave_up;
    logic                   live_octave_down;
    logic [KEY_ID_BITS-1:0] song_key_id;
    logic                   song_key_is_pressed;
    logic                   song_octave_up_feed;
    logic                   song_octave_down_feed;
    logic                   is_song_playing;
    logic                   song_play_level;
    logic [KEY_ID_BITS-1:0] out_key_id;
    logic                   out_key_pressed;
    logic                   out_octave_up;
    logic                   out_octave_down;
    logic [1:0]             active_source;

    modport slave (
        input  play_toggle_pulse,
        input  live_key_id,
        input  live_key_pressed,
        input  live_octave_up,
        input  live_octave_down,
        input  song_key_id,
        input  song_key_is_pressed,
        input  song_octave_up_feed,
        input  song_octave_down_feed,
        input  is_song_playing,
        output song_play_level,
        output out_key_id,
        output out_key_pressed,
        output out_octave_up,
        output out_octave_down,
        output active_source
    );

    modport master (
        output play_toggle_pulse,
        output live_key_id,
        output live_key_pressed,
        output live_octave_up,
        output live_octave_down,
        output song_key_id,
        output song_key_is_pressed,
        output song_octave_up_feed,
        output song_octave_down_feed,
        output is_song_playing,
        input  song_play_level,
        input  out_key_id,
        input  out_key_pressed,
        input  out_octave_up,
        input  out_octave_down,
        input  active_source
    );

endinterface

// File: rtl/piano_source_arbiter_countdown.sv
// Loadable down-counter shared by start timeout, holdoff and gap.
// done is high while the count sits at zero.
module arb_countdown #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/piano_source_arbiter.sv
// Selects live keyboard or song player for the tone generator and
// owns the player's play level (start, live pre-emption, stop/end).
module piano_source_arbiter
    import piano_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int KEY_ID_BITS    = 4,
    parameter int HOLDOFF_CYCLES = 25_000_000,
    parameter int GAP_CYCLES     = 2_500,
    parameter int START_TIMEOUT  = 8
) (
    input  logic           clk,
    input  logic           rst,
    piano_source_if.slave  bus
);

    localparam int CNT_MAX = max3(HOLDOFF_CYCLES, GAP_CYCLES, START_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] START_LD = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

    if (CLK_FREQ_HZ < 1 || HOLDOFF_CYCLES < 1 || GAP_CYCLES < 1 ||
        START_TIMEOUT < 1 || KEY_ID_BITS != piano_pkg::KEY_ID_BITS) begin : g_bad_cfg
        $error("piano_source_arbiter: invalid parameter set");
    end

    arb_state_t    state;
    arb_state_t    nxt;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_done;
    logic          stop;

    arb_countdown #(.WIDTH(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // A user toggle and the song's natural end collapse into one stop.
    assign stop = bus.play_toggle_pulse || !bus.is_song_playing;

    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            S_IDLE: begin
                if (bus.play_toggle_pulse) begin
                    nxt      = S_REQ;
                    cnt_load = 1'b1;
                    cnt_val  = START_LD;
                end
            end
            S_REQ: begin
                if (bus.is_song_playing) nxt = S_SONG;
                else if (cnt_done)       nxt = S_IDLE;
            end
            S_SONG: begin
                if (stop)                      nxt = S_IDLE;
                else if (bus.live_key_pressed) nxt = S_LIVE_OVR;
            end
            S_LIVE_OVR: begin
                if (stop) begin
                    nxt = S_IDLE;
                end else if (!bus.live_key_pressed) begin
                    nxt      = S_HOLDOFF;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            S_HOLDOFF: begin
                if (stop) begin
                    nxt = S_IDLE;
                end else if (bus.live_key_pressed) begin
                    nxt = S_LIVE_OVR;
                end else if (cnt_done) begin
                    nxt      = S_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LD;
                end
            end
            S_GAP: begin
                if (stop)                      nxt = S_IDLE;
                else if (bus.live_key_pressed) nxt = S_LIVE_OVR;
                else if (cnt_done)             nxt = S_SONG;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs reflect the state being entered, one cycle after the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            bus.song_play_level <= 1'b0;
            bus.out_key_id      <= REST;
            bus.out_key_pressed <= 1'b0;
            bus.out_octave_up   <= 1'b0;
            bus.out_octave_down <= 1'b0;
            bus.active_source   <= SRC_NONE;
        end else begin
            state               <= nxt;
            bus.song_play_level <= (nxt != S_IDLE);
            case (nxt)
                S_IDLE, S_LIVE_OVR: begin
                    bus.out_key_id      <= bus.live_key_id;
                    bus.out_key_pressed <= bus.live_key_pressed;
                    bus.out_octave_up   <= bus.live_octave_up;
                    bus.out_octave_down <= bus.live_octave_down;
                    bus.active_source   <= (nxt == S_LIVE_OVR || bus.live_key_pressed)
                                           ? SRC_LIVE : SRC_NONE;
                end
                S_SONG: begin
                    bus.out_key_id      <= bus.song_key_id;
                    bus.out_key_pressed <= bus.song_key_is_pressed;
                    bus.out_octave_up   <= bus.song_octave_up_feed;
                    bus.out_octave_down <= bus.song_octave_down_feed;
                    bus.active_source   <= SRC_SONG;
                end
                default: begin
                    bus.out_key_id      <= REST;
                    bus.out_key_pressed <= 1'b0;
                    bus.out_octave_up   <= 1'b0;
                    bus.out_octave_down <= 1'b0;
                    bus.active_source   <= SRC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_source_arbiter.sv
// Directed self-checking bench for piano_source_arbiter.
// Small holdoff/gap values keep the pre-emption timing visible.
module tb_piano_source_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;

    piano_source_if bus ();

    piano_source_arbiter #(
        .CLK_FREQ_HZ    (50_000_000),
        .KEY_ID_BITS    (4),
        .HOLDOFF_CYCLES (100),
        .GAP_CYCLES     (10),
        .START_TIMEOUT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_muted(output int cnt);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.out_key_pressed) break;
            cnt++;
        end
    endtask

    initial begin
        bus.play_toggle_pulse     = 1'b0;
        bus.live_key_id           = '0;
        bus.live_key_pressed      = 1'b0;
        bus.live_octave_up        = 1'b0;
        bus.live_octave_down      = 1'b0;
        bus.song_key_id           = '0;
        bus.song_key_is_pressed   = 1'b0;
        bus.song_octave_up_feed   = 1'b0;
        bus.song_octave_down_feed = 1'b0;
        bus.is_song_playing       = 1'b0;

        tick();
        tick();
        chk("rst_level", bus.song_play_level, 0);
        chk("rst_pressed", bus.out_key_pressed, 0);
        chk("rst_src", bus.active_source, 2'b00);
        chk("rst_id", bus.out_key_id, 0);
        rst = 1'b0;

        // idle passes live through
        bus.live_key_id      = 4'd9;
        bus.live_key_pressed = 1'b1;
        bus.live_octave_up   = 1'b1;
        tick();
        chk("idle_live_id", bus.out_key_id, 9);
        chk("idle_live_src", bus.active_source, 2'b01);
        chk("idle_live_oct", bus.out_octave_up, 1);
        chk("idle_level", bus.song_play_level, 0);
        bus.live_key_id      = '0;
        bus.live_key_pressed = 1'b0;
        bus.live_octave_up   = 1'b0;

        // play start
        bus.song_key_id           = 4'd5;
        bus.song_key_is_pressed   = 1'b1;
        bus.song_octave_down_feed = 1'b1;
        bus.play_toggle_pulse     = 1'b1;
        tick();
        bus.play_toggle_pulse = 1'b0;
        chk("start_level", bus.song_play_level, 1);
        chk("req_src", bus.active_source, 2'b00);
        chk("req_pressed", bus.out_key_pressed, 0);
        tick();
        bus.is_song_playing = 1'b1;
        tick();
        chk("song_id", bus.out_key_id, 5);
        chk("song_pressed", bus.out_key_pressed, 1);
        chk("song_src", bus.active_source, 2'b10);
        chk("song_oct_dn", bus.out_octave_down, 1);

        // pre-emption by live key 3
        bus.live_key_id      = 4'd3;
        bus.live_key_pressed = 1'b1;
        bus.live_octave_up   = 1'b1;
        tick();
        chk("ovr_id", bus.out_key_id, 3);
        chk("ovr_src", bus.active_source, 2'b01);
        chk("ovr_oct_up", bus.out_octave_up, 1);
        chk("ovr_oct_dn", bus.out_octave_down, 0);
        chk("ovr_level", bus.song_play_level, 1);
        repeat (3) tick();
        bus.live_key_pressed = 1'b0;
        bus.live_octave_up   = 1'b0;
        count_muted(n);
        chk("mute_len", n, 110);
        chk("resume_id", bus.out_key_id, 5);
        chk("resume_src", bus.active_source, 2'b10);

        // re-press at gap cycle 5
        bus.live_key_pressed = 1'b1;
        tick();
        chk("ovr2_src", bus.active_source, 2'b01);
        bus.live_key_pressed = 1'b0;
        repeat (105) tick();
        chk("gap5_src", bus.active_source, 2'b00);
        chk("gap5_pressed", bus.out_key_pressed, 0);
        bus.live_key_pressed = 1'b1;
        tick();
        chk("gap_abort_src", bus.active_source, 2'b01);
        chk("gap_abort_id", bus.out_key_id, 3);
        bus.live_key_pressed = 1'b0;
        count_muted(n);
        chk("mute_len2", n, 110);
        chk("resume2_src", bus.active_source, 2'b10);

        // toggle coincident with song end
        bus.play_toggle_pulse = 1'b1;
        bus.is_song_playing   = 1'b0;
        tick();
        bus.play_toggle_pulse = 1'b0;
        chk("coinc_level", bus.song_play_level, 0);
        tick();
        tick();
        chk("coinc_norestart", bus.song_play_level, 0);
        chk("coinc_src", bus.active_source, 2'b00);

        // natural end
        bus.play_toggle_pulse = 1'b1;
        tick();
        bus.play_toggle_pulse = 1'b0;
        tick();
        bus.is_song_playing = 1'b1;
        tick();
        chk("song3_src", bus.active_source, 2'b10);
        bus.is_song_playing = 1'b0;
        tick();
        chk("end_level", bus.song_play_level, 0);
        bus.play_toggle_pulse = 1'b1;
        tick();
        bus.play_toggle_pulse = 1'b0;
        chk("restart_level", bus.song_play_level, 1);

        // start timeout
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.song_play_level) break;
            n++;
        end
        chk("timeout_len", n, 8);
        bus.live_key_id      = 4'd7;
        bus.live_key_pressed = 1'b1;
        tick();
        chk("to_idle_id", bus.out_key_id, 7);
        chk("to_idle_src", bus.active_source, 2'b01);
        chk("to_idle_level", bus.song_play_level, 0);
        bus.live_key_pressed = 1'b0;

        // reset during live override
        bus.play_toggle_pulse = 1'b1;
        tick();
        bus.play_toggle_pulse = 1'b0;
        tick();
        bus.is_song_playing = 1'b1;
        tick();
        bus.live_key_id      = 4'd3;
        bus.live_key_pressed = 1'b1;
        tick();
        chk("ovr3_src", bus.active_source, 2'b01);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", bus.song_play_level, 0);
        chk("mid_rst_id", bus.out_key_id, 0);
        chk("mid_rst_pressed", bus.out_key_pressed, 0);
        chk("mid_rst_src", bus.active_source, 2'b00);
        rst = 1'b0;
        tick();
        chk("post_rst_level", bus.song_play_level, 0);
        chk("post_rst_src", bus.active_source, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
